// File: rtl/fw_loader.sv
// Firmware loader: takes a length/payload/checksum byte stream, writes the words
// into the instruction ROM and releases the core once the image checks out.
//
// state  | meaning
// BOOT   | one cycle after reset, samples load_en_i
// LEN    | collecting the 4-byte word count
// DATA   | collecting payload words, one ROM write per word
// CSUM   | collecting the 4-byte checksum
// DONE   | image loaded (or bypassed), core released
// ERR    | load failed, err_o holds the cause
module fw_loader #(
    parameter int unsigned ROM_DEPTH   = 4096,
    parameter int unsigned ROM_AW      = 12,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              rom_we_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [31:0]       rom_wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        err_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] TO_LOAD  = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] DEPTH32  = 32'(ROM_DEPTH);
    localparam logic [ROM_AW:0] IDX_ONE = {{ROM_AW{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        err_d;
    logic [1:0]        byte_cnt_q;
    logic [31:0]       asm_q;
    logic [31:0]       full_word;
    logic [ROM_AW:0]   idx_q;
    logic [ROM_AW:0]   n_q;
    logic [31:0]       sum_q;
    logic [31:0]       to_cnt_q;
    logic              accept;
    logic              last_byte;
    logic              to_hit;
    logic              active_d;

    logic              rx_ready_q;
    logic              rom_we_q;
    logic [ROM_AW-1:0] rom_addr_q;
    logic [31:0]       rom_wdata_q;
    logic              core_rst_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        err_q;

    assign accept    = rx_valid_i & rx_ready_q;
    assign last_byte = accept && (byte_cnt_q == 2'd3);
    // Little-endian assembly: each new byte enters at the top and shifts down.
    assign full_word = {rx_data_i, asm_q[31:8]};
    assign to_hit    = (TIMEOUT_CYC != 0) && busy_q && !accept && (to_cnt_q == 32'd0);
    assign active_d  = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);

    always_comb begin
        state_d = state_q;
        err_d   = 2'd0;
        case (state_q)
            S_BOOT: state_d = load_en_i ? S_LEN : S_DONE;
            S_LEN: begin
                if (last_byte) begin
                    if ((full_word == 32'd0) || (full_word > DEPTH32)) begin
                        state_d = S_ERR;
                        err_d   = 2'd1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte && (idx_q == (n_q - IDX_ONE))) state_d = S_CSUM;
            end
            S_CSUM: begin
                if (last_byte) begin
                    if (full_word == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 2'd2;
                    end
                end
            end
            default: ;
        endcase
        if (to_hit) begin
            state_d = S_ERR;
            err_d   = 2'd3;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_BOOT;
            byte_cnt_q  <= 2'd0;
            asm_q       <= 32'd0;
            idx_q       <= '0;
            n_q         <= '0;
            sum_q       <= 32'd0;
            to_cnt_q    <= 32'd0;
            rx_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= 32'd0;
            core_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 2'd0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= active_d;
            busy_q     <= active_d && (busy_q || accept);
            done_q     <= (state_d == S_DONE);
            core_rst_q <= (state_q == S_DONE);
            rom_we_q   <= 1'b0;
            if ((state_q != S_ERR) && (state_d == S_ERR)) err_q <= err_d;

            if (accept) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                asm_q      <= full_word;
            end

            // Idle timer counts down from the last accepted byte.
            if (accept) begin
                to_cnt_q <= TO_LOAD;
            end else if (to_cnt_q != 32'd0) begin
                to_cnt_q <= to_cnt_q - 32'd1;
            end

            if ((state_q == S_LEN) && last_byte) begin
                n_q   <= full_word[ROM_AW:0];
                idx_q <= '0;
                sum_q <= 32'd0;
            end

            if ((state_q == S_DATA) && last_byte) begin
                rom_we_q    <= 1'b1;
                rom_addr_q  <= idx_q[ROM_AW-1:0];
                rom_wdata_q <= full_word;
                sum_q       <= sum_q + full_word;
                idx_q       <= idx_q + IDX_ONE;
            end
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign rom_we_o    = rom_we_q;
    assign rom_addr_o  = rom_addr_q;
    assign rom_wdata_o = rom_wdata_q;
    assign core_rst_no = core_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_fw_loader.sv
// Bench for fw_loader: directed streams feed an expected-write queue that a
// negedge monitor drains; status outputs are checked against hand-derived values.
module tb_fw_loader;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          load_en_i = 1'b0;
    logic          rx_valid_i = 1'b0;
    logic [7:0]    rx_data_i = 8'h00;
    logic          rx_ready_o;
    logic          rom_we_o;
    logic [AW-1:0] rom_addr_o;
    logic [31:0]   rom_wdata_o;
    logic          core_rst_no;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    err_o;

    int vectors = 0;
    int errors  = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] exp_w;
    logic [7:0]     stim[$];

    fw_loader #(.ROM_DEPTH(DEPTH), .ROM_AW(AW), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .load_en_i(load_en_i),
        .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
        .rom_we_o(rom_we_o), .rom_addr_o(rom_addr_o), .rom_wdata_o(rom_wdata_o),
        .core_rst_no(core_rst_no), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (rst_ni && rom_we_o) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", rom_addr_o, rom_wdata_o);
            end else begin
                exp_w = exp_q.pop_front();
                if ({rom_addr_o, rom_wdata_o} !== exp_w) begin
                    errors++;
                    $display("FAIL rom_write: got addr %h data %h, expected addr %h data %h",
                             rom_addr_o, rom_wdata_o, exp_w[AW+31:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_rx_ready", 32'(rx_ready_o), 0);
        chk("rst_rom_we", 32'(rom_we_o), 0);
        chk("rst_rom_addr", 32'(rom_addr_o), 0);
        chk("rst_rom_wdata", rom_wdata_o, 0);
        chk("rst_core_rst_n", 32'(core_rst_no), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_err", 32'(err_o), 0);
    endtask

    task automatic reset_pulse();
        rx_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk_all_zero();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Resets with load enabled and waits out the BOOT cycle.
    task automatic start_load();
        load_en_i = 1'b1;
        reset_pulse();
        @(posedge clk_i);
        #1;
        chk("len_ready", 32'(rx_ready_o), 1);
        chk("len_busy_idle", 32'(busy_o), 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int cyc;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        acc = 1'b0;
        cyc = 0;
        while (!acc && cyc < 64) begin
            @(negedge clk_i);
            acc = rx_ready_o;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within %0d cycles", b, cyc);
        end
    endtask

    task automatic push32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(8'(w >> (8 * i)));
    endtask

    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({AW'(addr), data});
    endtask

    // Sends the queued stream; with gaps, idle lengths cycle through 0..15.
    task automatic send_all(input bit gaps);
        int n;
        n = 0;
        while (stim.size() > 0) begin
            send_byte(stim.pop_front());
            if (gaps && stim.size() > 0) begin
                rx_valid_i = 1'b0;
                repeat ((n * 7) % 16) @(posedge clk_i);
                #1;
            end
            n++;
        end
        rx_valid_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, s;

        // Bypass
        load_en_i = 1'b0;
        reset_pulse();
        @(posedge clk_i); #1;
        chk("byp_done", 32'(done_o), 1);
        chk("byp_core_held", 32'(core_rst_no), 0);
        @(posedge clk_i); #1;
        chk("byp_core_rel", 32'(core_rst_no), 1);
        repeat (4) @(posedge clk_i); #1;
        chk("byp_err", 32'(err_o), 0);
        chk("byp_ready", 32'(rx_ready_o), 0);

        // Nominal
        start_load();
        push32(32'd2); push32(32'h0000_0013); push32(32'hDEAD_BEEF); push32(32'hDEAD_BF02);
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'hDEAD_BEEF);
        send_all(1'b0);
        chk("nom_done", 32'(done_o), 1);
        chk("nom_busy", 32'(busy_o), 0);
        @(posedge clk_i); #1;
        chk("nom_core_rel", 32'(core_rst_no), 1);
        chk("nom_err", 32'(err_o), 0);
        chk("nom_ready", 32'(rx_ready_o), 0);
        chk("nom_pending", 32'(exp_q.size()), 0);

        // Checksum error
        start_load();
        push32(32'd2); push32(32'h0000_0013); push32(32'hDEAD_BEEF); push32(32'hDEAD_BF03);
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'hDEAD_BEEF);
        send_all(1'b0);
        chk("cs_err", 32'(err_o), 2);
        repeat (3) @(posedge clk_i); #1;
        chk("cs_done", 32'(done_o), 0);
        chk("cs_core_held", 32'(core_rst_no), 0);
        chk("cs_ready", 32'(rx_ready_o), 0);
        chk("cs_pending", 32'(exp_q.size()), 0);

        // Bad lengths
        start_load();
        push32(32'd0);
        send_all(1'b0);
        chk("len0_err", 32'(err_o), 1);
        chk("len0_busy", 32'(busy_o), 0);
        start_load();
        push32(32'd4097);
        send_all(1'b0);
        chk("len4097_err", 32'(err_o), 1);
        chk("len4097_ready", 32'(rx_ready_o), 0);

        // Full-depth image
        start_load();
        push32(32'd4096);
        s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'(i) * 32'h9E37_79B1 + 32'd1;
            s = s + w;
            push32(w);
            expect_write(i, w);
        end
        push32(s);
        send_all(1'b0);
        chk("full_done", 32'(done_o), 1);
        chk("full_err", 32'(err_o), 0);
        chk("full_pending", 32'(exp_q.size()), 0);

        // Gaps up to 15 idle cycles
        start_load();
        push32(32'd2); push32(32'h1234_5678); push32(32'h0F0F_0F0F); push32(32'h2143_6587);
        expect_write(0, 32'h1234_5678);
        expect_write(1, 32'h0F0F_0F0F);
        send_all(1'b1);
        chk("gap_done", 32'(done_o), 1);
        chk("gap_err", 32'(err_o), 0);
        chk("gap_pending", 32'(exp_q.size()), 0);

        // Timeout after 3 data bytes
        start_load();
        push32(32'd1);
        stim.push_back(8'hAA); stim.push_back(8'hBB); stim.push_back(8'hCC);
        send_all(1'b0);
        repeat (15) @(posedge clk_i); #1;
        chk("to_early_err", 32'(err_o), 0);
        chk("to_early_busy", 32'(busy_o), 1);
        @(posedge clk_i); #1;
        chk("to_err", 32'(err_o), 3);
        chk("to_busy", 32'(busy_o), 0);
        chk("to_ready", 32'(rx_ready_o), 0);

        // Reset mid-DATA, then a fresh single-word load
        start_load();
        push32(32'd2); push32(32'h5555_AAAA);
        expect_write(0, 32'h5555_AAAA);
        send_all(1'b0);
        @(negedge clk_i); #1;
        chk("mid_pending", 32'(exp_q.size()), 0);
        start_load();
        push32(32'd1); push32(32'hCAFE_F00D); push32(32'hCAFE_F00D);
        expect_write(0, 32'hCAFE_F00D);
        send_all(1'b0);
        chk("fresh_done", 32'(done_o), 1);
        chk("fresh_err", 32'(err_o), 0);
        @(posedge clk_i); #1;
        chk("fresh_core_rel", 32'(core_rst_no), 1);
        chk("fresh_pending", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fw_loader.md
Name: fw_loader

Overview:
- Synthesizable firmware loader that sits upstream of the SoC instruction ROM.
- Receives a byte stream (host UART/JTAG bridge or bench driver) carrying a length header, payload words and a checksum.
- Assembles little-endian 32-bit words and writes them into the ROM write port.
- Holds the core in reset until the image is loaded and verified, replacing simulation-only ROM preloading on FPGA and in gate-level runs.

Parameters:
ROM_DEPTH, 4096, ROM size in 32-bit words; maximum legal image length.
ROM_AW, 12, ROM word-address width; must satisfy 2**ROM_AW >= ROM_DEPTH.
TIMEOUT_CYC, 1000000, idle cycles allowed between accepted bytes once a transfer has started; 0 disables the timeout.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
load_en_i  in  1  1 = load an image over the stream; 0 = boot from existing ROM contents.
rx_valid_i  in  1  stream byte valid.
rx_data_i  in  8  stream byte.
rx_ready_o  out  1  loader accepts a byte this cycle.
rom_we_o  out  1  ROM write strobe, single-cycle pulse.
rom_addr_o  out  ROM_AW  ROM word address.
rom_wdata_o  out  32  ROM write data.
core_rst_no  out  1  core reset, active-low.
busy_o  out  1  transfer in progress.
done_o  out  1  load finished OK, or bypassed; sticky.
err_o  out  2  sticky error code: 0 none, 1 bad length, 2 checksum mismatch, 3 timeout.

Behaviour:
- Reset values: all outputs 0. In particular, core_rst_no=0, so the core is held in reset. Internal state is BOOT.
- Reset may assert asynchronously at any time, including mid-transfer. It returns the block to BOOT and discards any partial word and counters. ROM contents already written are not touched.
- States: BOOT, LEN, DATA, CSUM, DONE, ERR.
- BOOT lasts one cycle and samples load_en_i:
  - load_en_i=0 -> DONE.
  - load_en_i=1 -> LEN.
- A byte is accepted when rx_valid_i & rx_ready_o.
- rx_ready_o is 1 only in LEN, DATA and CSUM. It is registered and consistent with the current state.
- Bytes arrive little-endian: byte 0 goes to [7:0], and so on.
- A 2-bit byte counter wraps after 4 bytes.
- LEN:
  - Collect 4 bytes forming N, the length in words.
  - On the 4th byte: if N==0 or N>ROM_DEPTH -> ERR with err=1. Otherwise -> DATA, with word index 0 and sum 0.
- DATA:
  - On the 4th byte of each word, in the next cycle: rom_we_o=1 for exactly one cycle, rom_addr_o = word index, rom_wdata_o = assembled word.
  - In the same cycle, sum += word (mod 2^32) and the index increments.
  - After the write of index N-1 -> CSUM.
  - rom_addr_o and rom_wdata_o hold their last values when rom_we_o=0.
  - Accepting the next byte in the write cycle is legal. Full throughput is 1 byte per cycle.
- CSUM:
  - Collect 4 bytes into C.
  - C==sum -> DONE. Otherwise -> ERR with err=2.
- busy_o=1 from the first accepted LEN byte until leaving CSUM, or until entering ERR.
- Timeout applies only while busy_o=1:
  - The counter clears on each accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYC without a byte -> ERR with err=3.
  - Waiting in LEN before the first byte never times out.
- DONE:
  - done_o=1 on the entry cycle; core_rst_no=1 from the following cycle onward.
  - The block stays in DONE until rst_ni.
- ERR:
  - err_o is set on entry; done_o=0 and core_rst_no=0.
  - The block stays in ERR until rst_ni.
  - No ROM writes occur after entering ERR.
- In DONE and ERR, rx_ready_o=0. Extra bytes from the stream are not consumed.
- Simultaneous events:
  - A byte accepted in the same cycle the timeout counter would expire counts as a byte, not a timeout.
  - load_en_i changes after BOOT are ignored.
- Counter widths:
  - Index counter is ROM_AW+1 bits, so N=ROM_DEPTH is legal.
  - Length comparison uses the full 32-bit N.

Test Plan:
- Bypass: load_en_i=0, no stream traffic -> done_o=1 in the cycle after BOOT, core_rst_no=1 the cycle after that, rom_we_o never asserted, err_o=0.
- Nominal: stream len=2, words 0x00000013 and 0xDEADBEEF, checksum 0xDEADBF02, back-to-back bytes -> rom writes (addr0, 0x00000013) then (addr1, 0xDEADBEEF), each a 1-cycle pulse; done_o=1, err_o=0, core released.
- Checksum error: same stream with checksum 0xDEADBF03 -> both words written, err_o=2, done_o=0, core_rst_no stays 0, rx_ready_o=0.
- Bad length:
  - len=0 -> err_o=1 right after the 4th header byte, no writes.
  - len=ROM_DEPTH+1 (4097) -> err_o=1 right after the 4th header byte, no writes.
  - len=ROM_DEPTH -> accepted.
- Timeout and gaps, with TIMEOUT_CYC=16:
  - Random rx_valid_i gaps of at most 15 cycles -> load completes.
  - Stop after 3 data bytes -> err_o=3 exactly 16 cycles after the last accepted byte.
- Reset mid-DATA: assert rst_ni low after word 0 is written -> all outputs 0 immediately. After release, a fresh len=1 load of 0xCAFEF00D (checksum 0xCAFEF00D) writes addr0 and completes with done_o=1.
